// File: rtl/instr_encoder_if.sv
// Request and instruction-RAM write bundle for instr_encoder.
// The master drives requests and RAM readiness; the slave is the encoder.
interface instr_encoder_if #(
  parameter int unsigned AddrW = 32,
  parameter int unsigned Depth = 256
);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic             start;
  logic [AddrW-1:0] base_addr;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_opcode;
  logic [3:0]       req_ctrl;
  logic [4:0]       req_rd;
  logic [4:0]       req_rs1;
  logic [4:0]       req_rs2;
  logic [31:0]      req_imm;
  logic             mem_write;
  logic             mem_ready;
  logic [AddrW-1:0] mem_addr;
  logic [31:0]      mem_data;
  logic [CntW-1:0]  word_count;
  logic             err;
  logic             full;

  modport master (
    output start, base_addr, req_valid, req_opcode, req_ctrl, req_rd, req_rs1, req_rs2,
           req_imm, mem_ready,
    input  req_ready, mem_write, mem_addr, mem_data, word_count, err, full
  );

  modport slave (
    input  start, base_addr, req_valid, req_opcode, req_ctrl, req_rd, req_rs1, req_rs2,
           req_imm, mem_ready,
    output req_ready, mem_write, mem_addr, mem_data, word_count, err, full
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction word builder streaming encoded words into instruction RAM.
// Illegal requests are consumed without a write and set the sticky err flag.
module instr_encoder #(
  parameter int unsigned AddrW = 32,
  parameter int unsigned Depth = 256
) (
  input logic           clk_i,
  input logic           rst_ni,
  instr_encoder_if.slave bus
);
  localparam int unsigned CntW = $clog2(Depth + 1);

  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpJal    = 5'b11011;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpOpImm  = 5'b00100;
  localparam logic [4:0] OpOp     = 5'b01100;

  typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

  state_e           state_q;
  logic             mem_write_q;
  logic [AddrW-1:0] base_q;
  logic [AddrW-1:0] mem_addr_q;
  logic [31:0]      mem_data_q;
  logic [CntW-1:0]  wc_q;
  logic             err_q;
  logic             full_q;

  logic [31:0] enc_word;
  logic        enc_ok;
  logic        start_ok;
  logic        wr_done;
  logic        req_ready;
  logic        accept;
  logic [CntW-1:0] wc_inc;

  // Field packing and legality check for one request.
  always_comb begin
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [31:0] imm;
    logic        i_ok, b_ok, j_ok, is_shift;
    f3       = bus.req_ctrl[2:0];
    op       = {bus.req_opcode, 2'b11};
    imm      = bus.req_imm;
    i_ok     = imm[31:11] == {21{imm[11]}};
    b_ok     = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    j_ok     = (imm[31:20] == {12{imm[20]}}) && !imm[0];
    is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    enc_word = 32'h0;
    enc_ok   = 1'b0;
    case (bus.req_opcode)
      OpLui, OpAuipc: begin
        enc_word = {imm[31:12], bus.req_rd, op};
        enc_ok   = imm[11:0] == 12'h0;
      end
      OpJal: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, op};
        enc_ok   = j_ok;
      end
      OpJalr: begin
        enc_word = {imm[11:0], bus.req_rs1, 3'b000, bus.req_rd, op};
        enc_ok   = i_ok;
      end
      OpLoad: begin
        enc_word = {imm[11:0], bus.req_rs1, f3, bus.req_rd, op};
        enc_ok   = i_ok && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OpOpImm: begin
        if (is_shift) begin
          enc_word = {1'b0, bus.req_ctrl[3], 5'b0, imm[4:0], bus.req_rs1, f3, bus.req_rd, op};
          enc_ok   = imm[31:5] == 27'h0;
        end else begin
          enc_word = {imm[11:0], bus.req_rs1, f3, bus.req_rd, op};
          enc_ok   = i_ok;
        end
      end
      OpStore: begin
        enc_word = {imm[11:5], bus.req_rs2, bus.req_rs1, f3, imm[4:0], op};
        enc_ok   = i_ok && (f3 < 3'b011);
      end
      OpBranch: begin
        enc_word = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, f3, imm[4:1], imm[11], op};
        enc_ok   = b_ok && (f3 != 3'b010) && (f3 != 3'b011);
      end
      OpOp: begin
        enc_word = {1'b0, bus.req_ctrl[3], 5'b0, bus.req_rs2, bus.req_rs1, f3, bus.req_rd, op};
        enc_ok   = 1'b1;
      end
      default: begin
        enc_word = 32'h0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  assign start_ok = bus.start && !mem_write_q;
  assign wr_done  = mem_write_q && bus.mem_ready;
  assign wc_inc   = wc_q + CntW'(wr_done);

  // A start cycle takes no request so the new session begins cleanly.
  assign req_ready = (state_q == StRun) && !start_ok && !full_q &&
                     (({1'b0, wc_q} + (CntW + 1)'(mem_write_q)) < (CntW + 1)'(Depth)) &&
                     (!mem_write_q || bus.mem_ready);
  assign accept    = bus.req_valid && req_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mem_write_q <= 1'b0;
      base_q      <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= 32'h0;
      wc_q        <= '0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
    end else if (start_ok) begin
      state_q <= StRun;
      base_q  <= bus.base_addr & ~AddrW'(3);
      wc_q    <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wc_q   <= wc_inc;
      full_q <= wc_inc == CntW'(Depth);
      if (wr_done) begin
        mem_write_q <= 1'b0;
      end
      if (accept) begin
        if (enc_ok) begin
          mem_write_q <= 1'b1;
          mem_addr_q  <= base_q + AddrW'({wc_inc, 2'b00});
          mem_data_q  <= enc_word;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (state_q == StRun && wc_inc == CntW'(Depth)) begin
        state_q <= StFull;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.word_count = wc_q;
  assign bus.err        = err_q;
  assign bus.full       = full_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table plus backpressure, full and reset sequences.
module tb_instr_encoder;
  localparam int unsigned AddrW = 32;
  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.AddrW(AddrW), .Depth(Depth)) bus ();

  instr_encoder #(.AddrW(AddrW), .Depth(Depth)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  opc;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rej;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic valid);
    bus.req_valid  = valid;
    bus.req_opcode = v.opc;
    bus.req_ctrl   = v.ctrl;
    bus.req_rd     = v.rd;
    bus.req_rs1    = v.rs1;
    bus.req_rs2    = v.rs2;
    bus.req_imm    = v.imm;
  endtask

  // Pulse start for one edge; returns at the following negedge with settled outputs.
  task automatic do_start(input logic [31:0] base);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t good_op, good_addi, bad_addi;
    vecs = '{
      '{5'b01100, 4'b0000, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 32'h003100B3},
      '{5'b01100, 4'b1000, 5'd3, 5'd1, 5'd2, 32'h0,        1'b0, 32'h402081B3},
      '{5'b00100, 4'b1101, 5'd5, 5'd5, 5'd0, 32'd3,        1'b0, 32'h4032D293},
      '{5'b00100, 4'b1101, 5'd5, 5'd5, 5'd0, 32'd32,       1'b1, 32'h0},
      '{5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00093},
      '{5'b00100, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b1, 32'h0},
      '{5'b01101, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123450B7},
      '{5'b01101, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h12345001, 1'b1, 32'h0},
      '{5'b11000, 4'b0000, 5'd0, 5'd1, 5'd0, 32'hFFFFFFFC, 1'b0, 32'hFE008EE3},
      '{5'b11000, 4'b0000, 5'd0, 5'd1, 5'd0, 32'd3,        1'b1, 32'h0},
      '{5'b11000, 4'b0010, 5'd0, 5'd1, 5'd0, 32'hFFFFFFFC, 1'b1, 32'h0},
      '{5'b01000, 4'b0010, 5'd0, 5'd2, 5'd1, 32'd8,        1'b0, 32'h00112423},
      '{5'b01000, 4'b0011, 5'd0, 5'd2, 5'd1, 32'd8,        1'b1, 32'h0},
      '{5'b00000, 4'b0010, 5'd1, 5'd2, 5'd0, 32'd4,        1'b0, 32'h00412083},
      '{5'b00000, 4'b0011, 5'd1, 5'd2, 5'd0, 32'd4,        1'b1, 32'h0},
      '{5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd8,        1'b0, 32'h008000EF},
      '{5'b11011, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b1, 32'h0},
      '{5'b11001, 4'b0000, 5'd0, 5'd1, 5'd0, 32'h0,        1'b0, 32'h00008067},
      '{5'b00101, 4'b0000, 5'd2, 5'd0, 5'd0, 32'h00001000, 1'b0, 32'h00001117},
      '{5'b11111, 4'b0000, 5'd1, 5'd0, 5'd0, 32'h0,        1'b1, 32'h0}
    };
    good_op   = vecs[0];
    good_addi = vecs[4];
    bad_addi  = vecs[5];

    bus.start     = 1'b0;
    bus.base_addr = 32'h0;
    bus.mem_ready = 1'b1;
    drive(good_op, 1'b0);

    // Reset values
    #12;
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_data", bus.mem_data, 32'h0);
    check("rst_word_count", 32'(bus.word_count), 32'd0);
    check("rst_err_full", {30'h0, bus.err, bus.full}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_req_ready", 32'(bus.req_ready), 32'd0);

    // Encoding table: one fresh session per vector
    for (int i = 0; i < 20; i++) begin
      do_start(32'h103);
      check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'd1);
      drive(vecs[i], 1'b1);
      step();
      drive(vecs[i], 1'b0);
      if (vecs[i].rej) begin
        check($sformatf("v%0d_rej_err", i), 32'(bus.err), 32'd1);
        check($sformatf("v%0d_rej_write", i), 32'(bus.mem_write), 32'd0);
      end else begin
        check($sformatf("v%0d_write", i), 32'(bus.mem_write), 32'd1);
        check($sformatf("v%0d_addr", i), bus.mem_addr, 32'h100);
        check($sformatf("v%0d_data", i), bus.mem_data, vecs[i].word);
        check($sformatf("v%0d_err", i), 32'(bus.err), 32'd0);
      end
      step();
      check($sformatf("v%0d_count", i), 32'(bus.word_count), vecs[i].rej ? 32'd0 : 32'd1);
      check($sformatf("v%0d_idle_write", i), 32'(bus.mem_write), 32'd0);
    end

    // Backpressure: write held while mem_ready is low
    do_start(32'h200);
    bus.mem_ready = 1'b0;
    drive(good_op, 1'b1);
    step();
    drive(good_addi, 1'b1);
    #1;
    for (int c = 0; c < 3; c++) begin
      check("bp_write", 32'(bus.mem_write), 32'd1);
      check("bp_addr", bus.mem_addr, 32'h200);
      check("bp_data", bus.mem_data, 32'h003100B3);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      check("bp_count", 32'(bus.word_count), 32'd0);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    step();
    drive(good_addi, 1'b0);
    check("bp_next_addr", bus.mem_addr, 32'h204);
    check("bp_next_data", bus.mem_data, 32'hFFF00093);
    check("bp_next_count", 32'(bus.word_count), 32'd1);
    step();
    check("bp_final_count", 32'(bus.word_count), 32'd2);
    check("bp_final_write", 32'(bus.mem_write), 32'd0);

    // Full: good, reject behind a pending write, then back-to-back to Depth
    do_start(32'h0);
    drive(good_op, 1'b1);
    step();
    drive(bad_addi, 1'b1);
    #1;
    check("rej_pend_ready", 32'(bus.req_ready), 32'd1);
    step();
    check("rej_pend_err", 32'(bus.err), 32'd1);
    check("rej_pend_count", 32'(bus.word_count), 32'd1);
    check("rej_pend_write", 32'(bus.mem_write), 32'd0);
    drive(good_addi, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("b2b_ready", 32'(bus.req_ready), 32'd1);
      step();
      check("b2b_addr", bus.mem_addr, 32'(4 * (k + 1)));
      check("b2b_write", 32'(bus.mem_write), 32'd1);
      check("b2b_count", 32'(bus.word_count), 32'(k + 1));
    end
    drive(good_addi, 1'b0);
    #1;
    check("last_slot_ready", 32'(bus.req_ready), 32'd0);
    step();
    check("full_count", 32'(bus.word_count), 32'd4);
    check("full_flag", 32'(bus.full), 32'd1);
    check("full_ready", 32'(bus.req_ready), 32'd0);
    check("full_write", 32'(bus.mem_write), 32'd0);
    do_start(32'h40);
    check("restart_full", 32'(bus.full), 32'd0);
    check("restart_count", 32'(bus.word_count), 32'd0);
    check("restart_err", 32'(bus.err), 32'd0);
    check("restart_ready", 32'(bus.req_ready), 32'd1);

    // Reset while a write is pending
    drive(good_op, 1'b1);
    step();
    step();
    drive(good_op, 1'b0);
    bus.mem_ready = 1'b0;
    check("prerst_write", 32'(bus.mem_write), 32'd1);
    check("prerst_count", 32'(bus.word_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_write", 32'(bus.mem_write), 32'd0);
    check("arst_count", 32'(bus.word_count), 32'd0);
    check("arst_addr", bus.mem_addr, 32'h0);
    check("arst_data", bus.mem_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    step();
    step();
    check("postrst_write", 32'(bus.mem_write), 32'd0);
    check("postrst_count", 32'(bus.word_count), 32'd0);
    check("postrst_ready", 32'(bus.req_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
